hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core.
- Sits beside the ID stage and keeps a shadow scoreboard of the EX/MEM/WB destination registers.
- Detects RAW and load-use hazards, and drives PC/IF-ID write enables, ID/EX bubble insertion and IF/ID, ID/EX flushes on jumps and taken branches.
- Provides EX-stage forwarding selects and a saturating stall counter.

Parameters:
INIT_CYCLES, 4, cycles after reset during which the PC and IF/ID are held (IMEM warm-up); legal range 1..15.
CNT_W, 16, width of the stall performance counter.

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
id_valid  in  1  ID holds a real instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_rd  in  5  ID destination register
id_uses_rs2  in  1  instruction reads rs2 (R, S, SB types)
id_reg_write  in  1  ID ctrl_wb[0] (RegWrite)
id_mem_read  in  1  ID ctrl_m[1] (MemRead)
id_jump  in  1  ID control_j (JAL/JALR resolved in ID)
ex_branch_taken  in  1  branch resolved taken in EX
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  zero the IF/ID instruction on the next edge
idex_bubble  out  1  load all-zero controls into ID/EX on the next edge
fwd_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
fwd_b  out  2  EX operand B select, same encoding
stall_cnt  out  CNT_W  count of load-use/RAW stall cycles, saturating

Behaviour:
- Reset (async, reset_n=0):
  - FSM enters INIT with the counter loaded to INIT_CYCLES.
  - All shadow entries are invalid; stall_cnt=0.
  - Outputs while reset is asserted: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, fwd_a=fwd_b=00.
- Shadow scoreboard: three registered entries, EX {v, rd, rw, mr, rs1, rs2}, MEM {v, rd, rw}, WB {v, rd, rw}.
  - Every edge: MEM<=EX, WB<=MEM.
  - EX<=ID fields, except EX.v<=0 when idex_bubble=1.
  - An entry with rd=0 has rw treated as 0; x0 never causes a hazard or a forward.
- FSM states INIT, RUN, FLUSH:
  - INIT: pc_write=ifid_write=0, idex_bubble=1, counter decrements; INIT->RUN when counter==1.
  - RUN: ex_branch_taken -> ifid_flush=1 and idex_bubble=1 this cycle, pc_write=1, next state FLUSH.
  - RUN: else id_jump -> ifid_flush=1, stay in RUN.
  - RUN: else hazard -> pc_write=ifid_write=0, idex_bubble=1, stall_cnt+1.
  - FLUSH: exactly one cycle; id_valid is treated as 0 (no hazard, no stall), then FLUSH->RUN.
- Priority: reset > ex_branch_taken > id_jump > hazard. A taken branch during a stall cycle aborts the stall, and that cycle does not increment stall_cnt.
- Hazard with FWD_EN defined: load-use only.
  - Condition: id_valid & EX.v & EX.mr & EX.rw & (EX.rd==id_rs1 | (id_uses_rs2 & EX.rd==id_rs2)).
  - Exactly 1 stall cycle, because the producer leaves EX.
- Outputs are combinational from shadow registers, FSM state and ID inputs; same-cycle response, no added latency.
- stall_cnt holds at all-ones and never wraps.

Optional Feature:
FWD_EN
- Defined:
  - fwd_a: 10 if MEM.v & MEM.rw & MEM.rd==EX.rs1; else 01 if WB.v & WB.rw & WB.rd==EX.rs1; else 00. EX/MEM has priority over MEM/WB.
  - fwd_b: same rule using EX.rs2.
  - Hazard detection covers load-use only.
- Undefined:
  - fwd_a=fwd_b=00 permanently.
  - Hazard = id_valid & any of EX or MEM (v & rw & rd matching id_rs1 or a used id_rs2).
  - The register file writes first, so a WB-stage producer needs no stall.
  - A dependent instruction stalls up to 2 cycles.

Decomposition:
- Shared package rv_pipe_pkg:
  - FWD_REGFILE/FWD_EXMEM/FWD_MEMWB constants.
  - FSM state typedef {INIT, RUN, FLUSH}.
  - Opcode localparams shared with the ID stage.
- One sub-module, hazard_scoreboard: the 3-entry shadow pipeline plus match comparators.
- hazard_ctrl keeps the FSM, priority logic, forwarding and the counter.

Test Plan:
- Reset, then idle: pc_write=0 for 4 cycles after reset_n rises, 1 from cycle 5; stall_cnt=0.
- LD x5 then ADD x6,x5,x7 (FWD_EN): one cycle with pc_write=0 and idex_bubble=1; next cycle fwd_a=01; stall_cnt=1.
- ADD x5 then SUB x8,x5,x5 (FWD_EN): no stall; fwd_a=fwd_b=10. Same sequence without FWD_EN: 2 stall cycles; stall_cnt=2.
- Load-use stall, with ex_branch_taken=1 in the same cycle: ifid_flush=1, pc_write=1, stall_cnt unchanged; next state FLUSH, where a hazard-matching ID instruction causes no stall.
- JAL in ID (id_jump=1): ifid_flush=1 for exactly one cycle, pc_write=1; ADD x0 as producer never forwards or stalls.
- Force stall_cnt to all-ones via CNT_W=2 and 4 stalls: it saturates at 3.
- Assert reset_n=0 mid-stall: outputs take their reset values immediately and shadow entries clear.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// rtl/rv_pipe_pkg.sv - shared pipeline types and constants for the RV32 5-stage core
package rv_pipe_pkg;

   // EX operand select encodings
   localparam logic [1:0] FWD_REGFILE = 2'b00;
   localparam logic [1:0] FWD_EXMEM   = 2'b10;
   localparam logic [1:0] FWD_MEMWB   = 2'b01;

   // Opcodes shared with the ID stage decoder
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } hz_state_e;

   // Destination-register view of one pipeline stage
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       rw;
   } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - shadow EX/MEM/WB destination tracking and match comparators
module hazard_scoreboard
   import rv_pipe_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_n_i,
   input  logic       id_valid_i,
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic [4:0] id_rd_i,
   input  logic       id_uses_rs2_i,
   input  logic       id_reg_write_i,
   input  logic       id_mem_read_i,
   input  logic       idex_bubble_i,
   output logic       ex_load_hit_o,
   output logic       ex_raw_hit_o,
   output logic       mem_raw_hit_o,
   output logic       ex_rs1_mem_o,
   output logic       ex_rs1_wb_o,
   output logic       ex_rs2_mem_o,
   output logic       ex_rs2_wb_o
);

   sb_entry_t  ex_q, mem_q, wb_q, ex_d;
   logic       ex_mr_q;
   logic [4:0] ex_rs1_q, ex_rs2_q;

   // rw is cleared for x0 on entry so no later stage ever matches x0
   assign ex_d = '{v: id_valid_i & ~idex_bubble_i,
                   rd: id_rd_i,
                   rw: id_reg_write_i & (id_rd_i != 5'd0)};

   function automatic logic writes(input sb_entry_t e, input logic [4:0] r);
      return e.v & e.rw & (e.rd == r);
   endfunction

   function automatic logic feeds(input sb_entry_t e, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic use2);
      return writes(e, rs1) | (use2 & writes(e, rs2));
   endfunction

   // Advance the shadow pipeline every cycle
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ex_q     <= '0;
         mem_q    <= '0;
         wb_q     <= '0;
         ex_mr_q  <= 1'b0;
         ex_rs1_q <= 5'd0;
         ex_rs2_q <= 5'd0;
      end else begin
         ex_q     <= ex_d;
         ex_mr_q  <= id_mem_read_i;
         ex_rs1_q <= id_rs1_i;
         ex_rs2_q <= id_rs2_i;
         mem_q    <= ex_q;
         wb_q     <= mem_q;
      end
   end

   assign ex_raw_hit_o  = feeds(ex_q, id_rs1_i, id_rs2_i, id_uses_rs2_i);
   assign ex_load_hit_o = ex_raw_hit_o & ex_mr_q;
   assign mem_raw_hit_o = feeds(mem_q, id_rs1_i, id_rs2_i, id_uses_rs2_i);
   assign ex_rs1_mem_o  = writes(mem_q, ex_rs1_q);
   assign ex_rs1_wb_o   = writes(wb_q, ex_rs1_q);
   assign ex_rs2_mem_o  = writes(mem_q, ex_rs2_q);
   assign ex_rs2_wb_o   = writes(wb_q, ex_rs2_q);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline sequencing, stalls, flushes and forwarding (optional FWD_EN)
module hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int INIT_CYCLES = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_uses_rs2,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             id_jump,
   input  logic             ex_branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt
);

   hz_state_e        state_q;
   logic [3:0]       init_cnt_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             eff_valid, eff_jump, hazard, stall;
   logic             ex_load_hit, ex_raw_hit, mem_raw_hit;
   logic             ex_rs1_mem, ex_rs1_wb, ex_rs2_mem, ex_rs2_wb;

   // The ID slot during FLUSH holds a squashed instruction
   assign eff_valid = id_valid & (state_q != ST_FLUSH);
   assign eff_jump  = id_jump & (state_q == ST_RUN);

   hazard_scoreboard u_sb (
      .clk_i          (clk),
      .reset_n_i      (reset_n),
      .id_valid_i     (eff_valid),
      .id_rs1_i       (id_rs1),
      .id_rs2_i       (id_rs2),
      .id_rd_i        (id_rd),
      .id_uses_rs2_i  (id_uses_rs2),
      .id_reg_write_i (id_reg_write),
      .id_mem_read_i  (id_mem_read),
      .idex_bubble_i  (idex_bubble),
      .ex_load_hit_o  (ex_load_hit),
      .ex_raw_hit_o   (ex_raw_hit),
      .mem_raw_hit_o  (mem_raw_hit),
      .ex_rs1_mem_o   (ex_rs1_mem),
      .ex_rs1_wb_o    (ex_rs1_wb),
      .ex_rs2_mem_o   (ex_rs2_mem),
      .ex_rs2_wb_o    (ex_rs2_wb)
   );

`ifdef FWD_EN
   // Forwarding covers ALU results; only a load in EX must wait a cycle
   assign hazard = eff_valid & ex_load_hit;
   assign fwd_a  = ex_rs1_mem ? FWD_EXMEM : (ex_rs1_wb ? FWD_MEMWB : FWD_REGFILE);
   assign fwd_b  = ex_rs2_mem ? FWD_EXMEM : (ex_rs2_wb ? FWD_MEMWB : FWD_REGFILE);
   logic unused_raw;
   assign unused_raw = ex_raw_hit ^ mem_raw_hit;
`else
   // No bypass: wait until the producer reaches WB (regfile writes first)
   assign hazard = eff_valid & (ex_raw_hit | mem_raw_hit);
   assign fwd_a  = FWD_REGFILE;
   assign fwd_b  = FWD_REGFILE;
   logic unused_fwd;
   assign unused_fwd = ^{ex_load_hit, ex_rs1_mem, ex_rs1_wb, ex_rs2_mem, ex_rs2_wb};
`endif

   // Enables and flushes by priority: branch > jump > hazard
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      stall       = 1'b0;
      if (state_q == ST_INIT) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (ex_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (eff_jump) begin
         ifid_flush  = 1'b1;
      end else if (hazard) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
         stall       = 1'b1;
      end
   end

   // Saturating increment of the stall counter
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   // Sequencer: IMEM warm-up, run, one-cycle post-branch squash
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_INIT;
         init_cnt_q <= 4'(INIT_CYCLES);
      end else begin
         case (state_q)
            ST_INIT: begin
               init_cnt_q <= init_cnt_q - 4'd1;
               if (init_cnt_q == 4'd1) state_q <= ST_RUN;
            end
            ST_RUN, ST_FLUSH: state_q <= ex_branch_taken ? ST_FLUSH : ST_RUN;
            default: state_q <= ST_INIT;
         endcase
      end
   end

   // Stall performance counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stall_cnt_q <= '0;
      else          stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a stage-history model
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       id_valid, id_uses_rs2, id_reg_write, id_mem_read, id_jump, ex_branch_taken;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       pc_write, ifid_write, ifid_flush, idex_bubble;
   logic [1:0] fwd_a, fwd_b;
   logic [15:0] stall_cnt;
   logic       s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
   logic [1:0] s_fwd_a, s_fwd_b;
   logic [1:0] s_stall_cnt;

   always #5 clk = ~clk;

   hazard_ctrl #(.INIT_CYCLES(4), .CNT_W(16)) u_dut (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt));

   hazard_ctrl #(.INIT_CYCLES(4), .CNT_W(2)) u_sat (
      .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_jump(id_jump), .ex_branch_taken(ex_branch_taken),
      .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
      .idex_bubble(s_idex_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt));

   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       rw;
      bit       mr;
      bit [4:0] rs1;
      bit [4:0] rs2;
   } slot_t;

   // History of what entered EX: [0]=EX, [1]=MEM, [2]=WB
   slot_t hist[$];
   int    init_left;
   bit    in_flush;
   int    cnt16, cnt2;
   bit    e_pc, e_ifw, e_flush, e_bub, e_stall;
   bit [1:0] e_fa, e_fb;
   int    tests = 0;
   int    fails = 0;

   function automatic bit writes_to(input slot_t s, input bit [4:0] r);
      return s.v && s.rw && (s.rd != 0) && (s.rd == r);
   endfunction

   function automatic bit [1:0] fwd_sel(input bit [4:0] r);
      if (writes_to(hist[1], r)) return 2'b10;
      if (writes_to(hist[2], r)) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      slot_t empty;
      empty = '{v: 0, rd: 0, rw: 0, mr: 0, rs1: 0, rs2: 0};
      hist = {};
      for (int i = 0; i < 3; i++) hist.push_back(empty);
      init_left = 4;
      in_flush  = 0;
      cnt16     = 0;
      cnt2      = 0;
   endtask

   task automatic model_eval();
      bit valid, haz, need0, need1;
      e_stall = 0;
      e_fa = 2'b00;
      e_fb = 2'b00;
      if (!reset_n || init_left > 0) begin
         {e_pc, e_ifw, e_flush, e_bub} = 4'b0011;
         return;
      end
`ifdef FWD_EN
      e_fa = fwd_sel(hist[0].rs1);
      e_fb = fwd_sel(hist[0].rs2);
`endif
      valid = id_valid && !in_flush;
      need0 = valid && (writes_to(hist[0], id_rs1) || (id_uses_rs2 && writes_to(hist[0], id_rs2)));
      need1 = valid && (writes_to(hist[1], id_rs1) || (id_uses_rs2 && writes_to(hist[1], id_rs2)));
`ifdef FWD_EN
      haz = need0 && hist[0].mr;
`else
      haz = need0 || need1;
`endif
      if (ex_branch_taken)            {e_pc, e_ifw, e_flush, e_bub} = 4'b1111;
      else if (id_jump && !in_flush)  {e_pc, e_ifw, e_flush, e_bub} = 4'b1110;
      else if (haz) begin
         {e_pc, e_ifw, e_flush, e_bub} = 4'b0001;
         e_stall = 1;
      end else                        {e_pc, e_ifw, e_flush, e_bub} = 4'b1100;
   endtask

   task automatic model_clock();
      slot_t s;
      if (!reset_n) begin
         model_reset();
         return;
      end
      s = '{v: id_valid && !in_flush && !e_bub, rd: id_rd, rw: id_reg_write,
            mr: id_mem_read, rs1: id_rs1, rs2: id_rs2};
      hist.push_front(s);
      void'(hist.pop_back());
      if (e_stall) begin
         if (cnt16 < 65535) cnt16++;
         if (cnt2 < 3) cnt2++;
      end
      if (init_left > 0) init_left--;
      else in_flush = ex_branch_taken;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc_write"}, 32'(pc_write), 32'(e_pc));
      check({tag, ".ifid_write"}, 32'(ifid_write), 32'(e_ifw));
      check({tag, ".ifid_flush"}, 32'(ifid_flush), 32'(e_flush));
      check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
      check({tag, ".fwd_a"}, 32'(fwd_a), 32'(e_fa));
      check({tag, ".fwd_b"}, 32'(fwd_b), 32'(e_fb));
      check({tag, ".stall_cnt"}, 32'(stall_cnt), cnt16);
      check({tag, ".sat_stall_cnt"}, 32'(s_stall_cnt), cnt2);
   endtask

   task automatic drive(input bit v, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                        input bit u2, input bit rw, input bit mr, input bit j, input bit br);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_uses_rs2 = u2;
      id_reg_write = rw; id_mem_read = mr; id_jump = j; ex_branch_taken = br;
   endtask

   task automatic step(input string tag);
      model_eval();
      #3;
      check_all(tag);
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         step("nop");
      end
   endtask

   // Present one instruction in ID and hold it while the model says it stalls
   task automatic issue(input string tag, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit u2, input bit rw, input bit mr);
      bit done = 0;
      for (int k = 0; k < 6 && !done; k++) begin
         drive(1, rs1, rs2, rd, u2, rw, mr, 0, 0);
         step(tag);
         done = !e_stall;
      end
      if (!done) begin
         tests++;
         fails++;
         $error("FAIL %s: still stalled after bound", tag);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #1;
      step("reset");
      step("reset");
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) step("init");

      issue("ld_x5", 5'd1, 5'd0, 5'd5, 0, 1, 1);
      issue("add_x6_x5_x7", 5'd5, 5'd7, 5'd6, 1, 1, 0);
      nops(3);

      issue("add_x5", 5'd1, 5'd2, 5'd5, 1, 1, 0);
      issue("sub_x8_x5_x5", 5'd5, 5'd5, 5'd8, 1, 1, 0);
      nops(3);

      issue("ld_x9", 5'd1, 5'd0, 5'd9, 0, 1, 1);
      drive(1, 5'd9, 5'd9, 5'd10, 1, 1, 0, 0, 1);
      step("stall_vs_branch");
      drive(1, 5'd9, 5'd9, 5'd10, 1, 1, 0, 0, 0);
      step("flush_slot");
      nops(3);

      drive(1, 5'd0, 5'd0, 5'd1, 0, 1, 0, 1, 0);
      step("jal");
      nops(1);
      issue("add_x0", 5'd1, 5'd2, 5'd0, 1, 1, 0);
      issue("add_x11_x0_x0", 5'd0, 5'd0, 5'd11, 1, 1, 0);
      issue("ld_x0", 5'd1, 5'd0, 5'd0, 0, 1, 1);
      issue("add_x12_x0", 5'd0, 5'd0, 5'd12, 1, 1, 0);
      nops(3);

      for (int i = 0; i < 4; i++) begin
         issue("sat_ld", 5'd1, 5'd0, 5'd13, 0, 1, 1);
         issue("sat_use", 5'd13, 5'd2, 5'd14, 1, 1, 0);
      end
      nops(3);

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
         step("rand");
      end
      nops(3);

      issue("rst_ld_x5", 5'd1, 5'd0, 5'd5, 0, 1, 1);
      drive(1, 5'd5, 5'd7, 5'd6, 1, 1, 0, 0, 0);
      model_eval();
      #3;
      check_all("pre_reset_stall");
      reset_n = 1'b0;
      #1;
      model_reset();
      model_eval();
      check_all("async_reset");
      @(posedge clk);
      model_clock();
      #1;
      reset_n = 1'b1;
      nops(5);
      issue("post_reset_add_x5", 5'd5, 5'd5, 5'd7, 1, 1, 0);
      nops(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
